// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order WB stage versus a queued auxiliary unit.
// Optional retire trace registers are built only when WB_ARB_TRACE_EN is defined.
module wb_port_arbiter #(
  parameter int AUX_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic [31:0] wb_pc,
  output logic        wb_stall,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_waddr,
  input  logic [31:0] aux_wdata,
  input  logic [31:0] aux_pc,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy_mask,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [3:0]  trace_wen,
  output logic [4:0]  trace_wnum,
  output logic [31:0] trace_wdata
);
  localparam int PW = (AUX_DEPTH > 1) ? $clog2(AUX_DEPTH) : 1;
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } aux_ent_t;

  aux_ent_t               fifo_q [AUX_DEPTH];
  logic [AUX_DEPTH-1:0]   slot_vld;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          starve_cnt;
  aux_ent_t               head;
  logic                   fifo_empty, fifo_full;
  logic                   wb_req, grant_wb, grant_aux, push;

  // One valid bit per slot: occupancy is in-order, so all-set is full and none-set is empty.
  assign fifo_empty = ~|slot_vld;
  assign fifo_full  = &slot_vld;
  assign head       = fifo_q[rd_ptr];

  assign wb_req    = wb_valid & wb_we & (wb_waddr != 5'd0);
  assign aux_ready = ~rst & ~fifo_full;
  assign push      = aux_valid & aux_ready & (aux_waddr != 5'd0);

  always_comb begin
    grant_wb  = 1'b0;
    grant_aux = 1'b0;
    wb_stall  = 1'b0;
    if (!rst) begin
      if (fifo_empty)                         grant_wb  = wb_req;
      else if (!wb_req)                       grant_aux = 1'b1;
      else if (starve_cnt < CW'(STARVE_MAX))  grant_wb  = 1'b1;
      else begin
        grant_aux = 1'b1;
        wb_stall  = 1'b1;
      end
    end
  end

  assign rf_wen   = grant_wb | grant_aux;
  assign rf_waddr = grant_aux ? head.waddr : wb_waddr;
  assign rf_wdata = grant_aux ? head.wdata : wb_wdata;

  always_comb begin
    busy_mask = '0;
    if (!rst) begin
      for (int i = 0; i < AUX_DEPTH; i++)
        if (slot_vld[i]) busy_mask[fifo_q[i].waddr] = 1'b1;
    end
  end

  // Push and pop never hit the same slot: that would need the FIFO both empty and full.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) begin
        slot_vld[wr_ptr] <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (grant_aux) begin
        slot_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      if (grant_aux || fifo_empty) starve_cnt <= '0;
      else if (grant_wb)           starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{waddr: aux_waddr, wdata: aux_wdata, pc: aux_pc};
  end

`ifdef WB_ARB_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_wen   <= '0;
      trace_wnum  <= '0;
      trace_wdata <= '0;
    end else begin
      trace_valid <= rf_wen | (wb_valid & ~wb_stall);
      trace_pc    <= grant_aux ? head.pc : wb_pc;
      trace_wen   <= {4{rf_wen}};
      trace_wnum  <= rf_waddr;
      trace_wdata <= rf_wdata;
    end
  end
`else
  logic trace_unused;
  assign trace_unused = ^{head.pc, wb_pc};
  assign trace_valid  = 1'b0;
  assign trace_pc     = '0;
  assign trace_wen    = '0;
  assign trace_wnum   = '0;
  assign trace_wdata  = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: per-cycle expected regfile writes are queued
// and popped by a write monitor; trace expectations follow WB_ARB_TRACE_EN.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata, wb_pc;
  logic        wb_stall;
  logic        aux_valid, aux_ready;
  logic [4:0]  aux_waddr;
  logic [31:0] aux_wdata, aux_pc;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, busy_mask;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [3:0]  trace_wen;
  logic [4:0]  trace_wnum;
  logic [31:0] trace_wdata;

  wb_port_arbiter #(.AUX_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_pc(wb_pc), .wb_stall(wb_stall),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_waddr(aux_waddr),
    .aux_wdata(aux_wdata), .aux_pc(aux_pc),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_mask(busy_mask),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_wen(trace_wen),
    .trace_wnum(trace_wnum), .trace_wdata(trace_wdata)
  );

  always #5 clk = ~clk;

`ifdef WB_ARB_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_chk  = 0;
  int  n_pass = 0;

  function automatic logic [31:0] tr(input logic [31:0] v);
    return TR ? v : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic expw(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wb(input logic v, input logic we, input logic [4:0] a,
                    input logic [31:0] d, input logic [31:0] pc);
    wb_valid = v; wb_we = we; wb_waddr = a; wb_wdata = d; wb_pc = pc;
  endtask

  task automatic aux(input logic v, input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] pc);
    aux_valid = v; aux_waddr = a; aux_wdata = d; aux_pc = pc;
  endtask

  // Every regfile write must match the oldest expected write, in order.
  always @(negedge clk) begin
    if (rf_wen === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", {27'b0, rf_waddr}, 32'hffff_ffff);
      else begin
        mon_e = exp_q.pop_front();
        chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, mon_e.a});
        chk("rf_wdata", rf_wdata, mon_e.d);
      end
    end
  end

  initial begin
    // reset with aux_valid held high
    rst = 1'b1;
    wb(0, 0, 0, 0, 0);
    aux(1, 5'd3, 32'h33, 32'h0);
    mid();
    chk("rst_aux_ready", aux_ready, 0);
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_stall", wb_stall, 0);
    tick(); tick();
    rst = 1'b0;
    aux(0, 0, 0, 0);
    mid();
    chk("post_rst_aux_ready", aux_ready, 1);
    chk("post_rst_busy", busy_mask, 0);
    chk("post_rst_trace_valid", trace_valid, 0);
    chk("post_rst_trace_wen", trace_wen, 0);
    chk("post_rst_trace_pc", trace_pc, 0);
    tick();

    // plain WB write through an empty FIFO
    wb(1, 1, 5'd5, 32'h1234, 32'h100);
    expw(5'd5, 32'h1234);
    mid();
    chk("wb_rf_wen", rf_wen, 1);
    chk("wb_stall", wb_stall, 0);
    tick();
    wb(1, 1, 5'd0, 32'h5555, 32'h104);
    mid();
    chk("trace_wen", trace_wen, tr(32'hf));
    chk("trace_wnum", trace_wnum, tr(5));
    chk("trace_wdata", trace_wdata, tr(32'h1234));
    chk("trace_pc", trace_pc, tr(32'h100));
    chk("trace_valid", trace_valid, tr(1));
    chk("wb_x0_no_write", rf_wen, 0);
    chk("wb_x0_no_stall", wb_stall, 0);
    tick();
    wb(0, 0, 0, 0, 0);

    // aux push, no bypass, written the next cycle
    aux(1, 5'd7, 32'hdeadbeef, 32'h200);
    mid();
    chk("aux_no_bypass", rf_wen, 0);
    chk("aux_busy_before", busy_mask, 0);
    tick();
    aux(0, 0, 0, 0);
    expw(5'd7, 32'hdeadbeef);
    mid();
    chk("aux_busy_r7", busy_mask, 32'h80);
    chk("aux_rf_wen", rf_wen, 1);
    tick();
    mid();
    chk("aux_busy_cleared", busy_mask, 0);
    chk("aux_trace_wnum", trace_wnum, tr(7));
    chk("aux_trace_pc", trace_pc, tr(32'h200));
    tick();

    // starvation: r9 queued while WB writes every cycle
    aux(1, 5'd9, 32'h99, 32'h300);
    mid();
    tick();
    aux(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      wb(1, 1, 5'(10 + k), 32'ha0 + k, 32'h400 + k);
      expw(5'(10 + k), 32'ha0 + k);
      mid();
      chk("starve_wb_no_stall", wb_stall, 0);
      chk("starve_busy_r9", busy_mask, 32'h200);
      tick();
    end
    wb(1, 1, 5'd14, 32'hb4, 32'h404);
    expw(5'd9, 32'h99);
    mid();
    chk("starve_stall", wb_stall, 1);
    tick();
    expw(5'd14, 32'hb4);
    mid();
    chk("starve_held_no_stall", wb_stall, 0);
    chk("starve_busy_clear", busy_mask, 0);
    chk("starve_trace_pc", trace_pc, tr(32'h300));
    chk("starve_trace_wnum", trace_wnum, tr(9));
    chk("starve_trace_valid", trace_valid, tr(1));
    tick();

    // FIFO fill: three back-to-back pushes while WB is busy
    wb(1, 1, 5'd20, 32'hc0, 32'h600);
    aux(1, 5'd16, 32'h16, 32'h500);
    expw(5'd20, 32'hc0);
    mid();
    chk("fill_ready1", aux_ready, 1);
    tick();
    wb(1, 1, 5'd21, 32'hc1, 32'h604);
    aux(1, 5'd17, 32'h17, 32'h504);
    expw(5'd21, 32'hc1);
    mid();
    chk("fill_ready2", aux_ready, 1);
    tick();
    wb(1, 1, 5'd22, 32'hc2, 32'h608);
    aux(1, 5'd18, 32'h18, 32'h508);
    expw(5'd22, 32'hc2);
    mid();
    chk("fill_full_not_ready", aux_ready, 0);
    chk("fill_busy", busy_mask, 32'h0003_0000);
    tick();
    wb(0, 0, 0, 0, 0);
    expw(5'd16, 32'h16);
    mid();
    chk("fill_no_bypass_when_full", aux_ready, 0);
    tick();
    expw(5'd17, 32'h17);
    mid();
    chk("fill_ready_again", aux_ready, 1);
    tick();
    aux(0, 0, 0, 0);
    expw(5'd18, 32'h18);
    mid();
    chk("fill_busy_r18", busy_mask, 32'h0004_0000);
    tick();

    // waddr 0 push is accepted and dropped
    aux(1, 5'd0, 32'hfeed, 32'h700);
    mid();
    chk("x0_ready", aux_ready, 1);
    tick();
    aux(0, 0, 0, 0);
    mid();
    chk("x0_busy", busy_mask, 0);
    chk("x0_no_write", rf_wen, 0);
    tick();

    // reset mid-operation discards queued entry
    aux(1, 5'd11, 32'h11, 32'h800);
    tick();
    aux(0, 0, 0, 0);
    rst = 1'b1;
    mid();
    chk("midrst_rf_wen", rf_wen, 0);
    tick();
    rst = 1'b0;
    mid();
    chk("midrst_busy", busy_mask, 0);
    chk("midrst_no_write", rf_wen, 0);
    tick(); tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order WB stage and a multi-cycle auxiliary unit (divider/multiplier) that returns results out of band. The WB stage always has the lower-latency path. Auxiliary results are queued in a small FIFO and drained on idle port cycles. A starvation counter forces a one-cycle WB stall so queued results cannot wait forever. The block sits between WB and the regfile, and exports a busy mask for ID-stage hazard detection plus a registered retire trace.

Parameters:
AUX_DEPTH, 2, auxiliary result FIFO depth; power of two, at least 2.
STARVE_MAX, 4, consecutive cycles a FIFO head may lose arbitration before a WB stall is forced; at least 1.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wb_valid  in  1  WB holds a valid instruction
wb_we  in  1  WB instruction writes a GPR
wb_waddr  in  5  WB destination register
wb_wdata  in  32  WB write data, CSR mux already applied
wb_pc  in  32  WB instruction PC
wb_stall  out  1  WB write not taken this cycle; upstream must hold WB contents
aux_valid  in  1  auxiliary result offered
aux_ready  out  1  FIFO can accept
aux_waddr  in  5  auxiliary destination register
aux_wdata  in  32  auxiliary result
aux_pc  in  32  PC of the producing instruction
rf_wen  out  1  regfile write enable
rf_waddr  out  5  regfile write address
rf_wdata  out  32  regfile write data
busy_mask  out  32  one-hot OR of destinations queued in the FIFO
trace_valid  out  1  registered: a write or retire happened last cycle
trace_pc  out  32  registered retire PC
trace_wen  out  4  registered, equal to {4{rf_wen}} of last cycle
trace_wnum  out  5  registered write address
trace_wdata  out  32  registered write data

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- On reset: FIFO empty, starvation counter 0, all trace_* outputs 0.
- Combinational outputs while rst is high: rf_wen 0, wb_stall 0, aux_ready 0, busy_mask 0.
- wb_req = wb_valid & wb_we & (wb_waddr != 0).
  - WB instructions with wb_we=0 or waddr 0 never need the port and are never stalled.
- FIFO enqueue when aux_valid & aux_ready, where aux_ready = !full.
  - No bypass: when full, no enqueue even if a dequeue happens in the same cycle.
  - An accepted entry with aux_waddr 0 is dropped: not stored, no write.
- Minimum latency from aux accept to rf write is 1 cycle; an empty FIFO does not bypass.
- Grant rules, evaluated each cycle:
  - FIFO empty: WB gets the port if wb_req.
  - FIFO non-empty and !wb_req: head is written and popped.
  - FIFO non-empty, wb_req, and counter < STARVE_MAX: WB is written and the counter increments.
  - FIFO non-empty, wb_req, and counter == STARVE_MAX: head is written and popped, wb_stall=1, counter cleared. The WB write happens on the next cycle with the same held inputs.
- The counter clears whenever the head is popped and holds at 0 when the FIFO is empty.
- Simultaneous enqueue and pop on a non-full FIFO is allowed; occupancy is unchanged.
- Pointers wrap modulo AUX_DEPTH, with a separate full flag or an extra pointer bit.
- busy_mask is updated combinationally from the current FIFO contents. The ID stage must stall any reader or writer of a busy register, so WB and the FIFO never target the same register out of order. The block does not check this.
- Trace registers are loaded every cycle:
  - trace_valid = rf_wen | (wb_valid & !wb_stall).
  - trace_pc = the pc of the granted source; if there is no write, wb_pc.
  - trace_wen = {4{rf_wen}}.
  - trace_wnum and trace_wdata = rf_waddr and rf_wdata.
- Reset mid-operation discards all queued entries. The auxiliary unit is reset by the same rst.

Optional Feature:
Macro WB_ARB_TRACE_EN.
- Defined: trace_* registers behave as above.
- Undefined: no trace flops are built; trace_* outputs are tied to 0. Arbitration behaviour is identical.

Test Plan:
- Reset with aux_valid=1 -> aux_ready=0; after reset deasserts, aux_ready=1, busy_mask=0, trace_*=0.
- Empty FIFO, wb_valid=1, wb_we=1, waddr=5, wdata=0x1234 -> same cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234, wb_stall=0; next cycle trace_wen=4'hf, trace_wnum=5.
- WB idle; aux push waddr=7, data=0xdeadbeef -> busy_mask bit 7 set next cycle; rf write of 0xdeadbeef to r7 on that cycle; mask clears after the pop.
- FIFO holding r9 while WB writes every cycle, STARVE_MAX=4 -> four WB writes, then in the fifth cycle wb_stall=1 and r9 is written; the held WB write lands in the sixth cycle.
- Three aux pushes back-to-back with WB busy, AUX_DEPTH=2 -> aux_ready drops after two accepts and the third is held; an aux push with waddr=0 is accepted with no rf write and no busy_mask bit set.
- Build without WB_ARB_TRACE_EN and rerun the second scenario -> rf behaviour identical, all trace_* outputs remain 0.
